page_allocator: RTL
===================

PAGE_ALLOCATOR -- requirements
Module: page_allocator

Interface
REQ-001 SHALL have parameter NUM_PAGES, default 256, which is the number of tracked pages (power of two, 16..1024).
REQ-002 SHALL have parameter IDX_W, default $clog2(NUM_PAGES), which is the page index width.
REQ-003 SHALL have port clk200, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port a8_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, 1 bit: request strobe, sampled only while ready=1.
REQ-006 SHALL have port op, input, 2 bits: 0 NOP, 1 MARK (set range used), 2 FREE (clear range), 3 ALLOC (first-fit search).
REQ-007 SHALL have port from, input, IDX_W bits: range start for MARK/FREE; ignored by ALLOC.
REQ-008 SHALL have port size, input, IDX_W+1 bits: page count for all ops.
REQ-009 SHALL have port ready, output, 1 bit: high when idle and able to accept a request.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port ok, output, 1 bit: result status, valid while done=1.
REQ-012 SHALL have port base, output, IDX_W bits: allocated start page, valid while done=1 and ok=1 after ALLOC.
REQ-013 SHALL have port map, output, NUM_PAGES bits: occupancy bitmap, 1 = used.
REQ-014 SHALL have port free_count, output, IDX_W+1 bits: number of zero bits in map.

Function
REQ-015 SHALL accept a request on an edge where req=1, ready=1 and op!=0; the inputs op/from/size SHALL be latched; ready SHALL go low on the next cycle.
REQ-016 SHALL ignore req when ready=0 or op=0 (no state change, no done).
REQ-017 SHALL implement the FSM states IDLE, APPLY, SCAN and DONE. IDLE->APPLY for MARK/FREE; IDLE->SCAN for ALLOC; APPLY->DONE; SCAN->DONE on a found run or exhaustion; DONE->IDLE unconditionally.
REQ-018 SHALL, in APPLY, set (MARK) or clear (FREE) bits from..from+size-1 in one edge, so map updates at acceptance+1 and done=1 in the following cycle.
REQ-019 SHALL reject MARK/FREE with size=0 or from+size>NUM_PAGES (computed at IDX_W+2 bits, no wrap): map unchanged, ok=0.
REQ-020 SHALL make MARK on already-used pages and FREE on already-free pages legal with ok=1; free_count reflects only the bits that actually changed.
REQ-021 SHALL have ALLOC scan one page per cycle from index 0 upward, keeping a contiguous-free run counter that resets on a used page.
REQ-022 SHALL, when the run reaches size at index i, set base=i-size+1, mark those pages used on the same edge as the DONE entry, and give ok=1; the total ALLOC latency is base+size+1 cycles from acceptance to done.
REQ-023 SHALL make ALLOC with size=0, size>free_count (checked at acceptance, skipping the scan) or no run found by index NUM_PAGES-1 give done with ok=0, map unchanged and base=0.
REQ-024 SHALL update free_count in the same edge as map; it never goes negative and never exceeds NUM_PAGES.
REQ-025 SHALL hold base and ok until the next done; done SHALL be exactly one cycle wide.

Reset
REQ-026 SHALL, on a8_rst_n=0, immediately set: map all zero, free_count=NUM_PAGES, FSM=IDLE, ready=1, done=0, ok=0, base=0, and clear the run counter.
REQ-027 SHALL, when reset is asserted mid-APPLY or mid-SCAN, abort the operation with no partial update surviving and no done pulse.

Structure
REQ-028 SHALL place the op encodings (NOP/MARK/FREE/ALLOC) and the FSM state encodings in shared package pixl_pkg.
REQ-029 SHALL place the range-mask generator (from, size -> NUM_PAGES-bit mask plus range-valid flag) in the combinational sub-module page_range_mask, for reuse by other page blocks.

Verification
REQ-030 SHALL verify: reset, then MARK from=6 size=4 -> map bits 6..9 set, free_count=252, ok=1, done 2 cycles after acceptance.
REQ-031 SHALL verify: after REQ-030, FREE from=6 size=2 -> bits 8,9 remain set, free_count=254, ok=1.
REQ-032 SHALL verify: with bits 8,9 used, ALLOC size=8 -> base=0, ok=1, bits 0..7 set, done 9 cycles after acceptance; a second ALLOC size=8 -> base=10.
REQ-033 SHALL verify: MARK from=250 size=8 -> ok=0 and map unchanged; ALLOC size=0 -> ok=0.
REQ-034 SHALL verify: all pages marked, then ALLOC size=1 -> ok=0 with no scan (done 2 cycles after acceptance); req while ready=0 -> ignored.
REQ-035 SHALL verify: assert a8_rst_n=0 during an ALLOC scan at cycle 5 -> map all zero, no done, ready=1 after release.

Source files
------------

// File: rtl/pixl_pkg.sv
// Shared encodings for the page-tracking blocks: request opcodes and allocator FSM states.
// Latency: none (type definitions only).
// Backpressure: n/a.
package pixl_pkg;

  // Request opcodes carried on the 2-bit op port.
  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_MARK  = 2'd1,
    OP_FREE  = 2'd2,
    OP_ALLOC = 2'd3
  } op_e;

  // Allocator control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/page_range_mask.sv
// Range-to-mask decoder: bits from..from+size-1 set, plus a flag saying the range fits the map.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: from/size in; mask (NUM_PAGES bits) and range_ok out. size=0 or overrun gives an empty mask.
module page_range_mask #(
  parameter int NUM_PAGES = 256,
  parameter int IDX_W     = $clog2(NUM_PAGES)
) (
  input  logic [IDX_W-1:0]     from,
  input  logic [IDX_W:0]       size,
  output logic [NUM_PAGES-1:0] mask,
  output logic                 range_ok
);

  // Two extra bits so from+size can never wrap before the bound check.
  localparam int EW = IDX_W + 2;

  logic [EW-1:0] lo_w;
  logic [EW-1:0] hi_w;

  always_comb begin
    lo_w     = EW'(from);
    hi_w     = lo_w + EW'(size);
    range_ok = (size != '0) && (hi_w <= EW'(NUM_PAGES));
    mask     = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      mask[i] = range_ok && (EW'(i) >= lo_w) && (EW'(i) < hi_w);
    end
  end

endmodule

// File: rtl/page_allocator.sv
// Page occupancy bitmap with range MARK/FREE and first-fit ALLOC (linear scan, one page per cycle).
// Latency: MARK/FREE and rejected ALLOC done 2 cycles after accept; found ALLOC done base+size+1 cycles after accept.
// Backpressure: ready is low from the cycle after accept until back in IDLE; req is ignored while ready=0.
// Ports: req/op/from/size request in; ready, done pulse, ok/base result (held to next done), map, free_count out.
module page_allocator
  import pixl_pkg::*;
#(
  parameter int NUM_PAGES = 256,
  parameter int IDX_W     = $clog2(NUM_PAGES)
) (
  input  logic                 clk200,
  input  logic                 a8_rst_n,
  input  logic                 req,
  input  logic [1:0]           op,
  input  logic [IDX_W-1:0]     from,
  input  logic [IDX_W:0]       size,
  output logic                 ready,
  output logic                 done,
  output logic                 ok,
  output logic [IDX_W-1:0]     base,
  output logic [NUM_PAGES-1:0] map,
  output logic [IDX_W:0]       free_count
);

  localparam int CW = IDX_W + 1;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [IDX_W-1:0]     from_q, from_d;
  logic [IDX_W:0]       size_q, size_d;
  logic                 rej_q, rej_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W:0]       run_q, run_d;
  logic [NUM_PAGES-1:0] map_q, map_d;
  logic [IDX_W:0]       free_q, free_d;
  logic                 ok_q, ok_d;
  logic [IDX_W-1:0]     base_q, base_d;

  logic                 acc_vld;
  logic [IDX_W-1:0]     scan_base;
  logic [IDX_W:0]       run_nx;
  logic [IDX_W-1:0]     rm_from;
  logic [NUM_PAGES-1:0] rm_mask;
  logic                 rm_ok;
  logic [NUM_PAGES-1:0] chg_map;
  logic [IDX_W:0]       chg_cnt;

  // Candidate start of the run ending at idx_q. Modular arithmetic also covers
  // size=NUM_PAGES, where the low size bits are zero and the result wraps to 0.
  assign scan_base = idx_q - size_q[IDX_W-1:0] + IDX_W'(1);
  assign run_nx    = map_q[idx_q] ? '0 : run_q + CW'(1);

  // One decoder serves both paths: latched range in APPLY, found run in SCAN.
  assign rm_from = (state_q == ST_SCAN) ? scan_base : from_q;

  page_range_mask #(
    .NUM_PAGES (NUM_PAGES),
    .IDX_W     (IDX_W)
  ) u_range (
    .from     (rm_from),
    .size     (size_q),
    .mask     (rm_mask),
    .range_ok (rm_ok)
  );

  assign acc_vld = (state_q == ST_IDLE) && req && (op != OP_NOP);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    from_d  = from_q;
    size_d  = size_q;
    rej_d   = rej_q;
    idx_d   = idx_q;
    run_d   = run_q;
    map_d   = map_q;
    ok_d    = ok_q;
    base_d  = base_q;

    case (state_q)
      ST_IDLE: begin
        if (acc_vld) begin
          op_d    = op_e'(op);
          from_d  = from;
          size_d  = size;
          idx_d   = '0;
          run_d   = '0;
          // Impossible ALLOCs are decided now so the scan is skipped entirely.
          rej_d   = (size == '0) || (size > free_q);
          state_d = (op == OP_ALLOC) ? ST_SCAN : ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d = ST_DONE;
        ok_d    = rm_ok;
        base_d  = '0;
        if (rm_ok) begin
          map_d = (op_q == OP_MARK) ? (map_q | rm_mask) : (map_q & ~rm_mask);
        end
      end
      ST_SCAN: begin
        if (rej_q) begin
          state_d = ST_DONE;
          ok_d    = 1'b0;
          base_d  = '0;
        end else if (run_nx == size_q) begin
          state_d = ST_DONE;
          ok_d    = 1'b1;
          base_d  = scan_base;
          map_d   = map_q | rm_mask;
        end else if (idx_q == IDX_W'(NUM_PAGES - 1)) begin
          state_d = ST_DONE;
          ok_d    = 1'b0;
          base_d  = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          run_d = run_nx;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // free_count moves only by the bits that actually flipped, so re-marking
  // used pages or re-freeing free pages leaves it untouched.
  always_comb begin
    chg_map = map_q ^ map_d;
    chg_cnt = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      chg_cnt = chg_cnt + CW'(chg_map[i]);
    end
    free_d = (op_q == OP_FREE) ? (free_q + chg_cnt) : (free_q - chg_cnt);
  end

  always_ff @(posedge clk200 or negedge a8_rst_n) begin
    if (!a8_rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      from_q  <= '0;
      size_q  <= '0;
      rej_q   <= 1'b0;
      idx_q   <= '0;
      run_q   <= '0;
      map_q   <= '0;
      free_q  <= CW'(NUM_PAGES);
      ok_q    <= 1'b0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      from_q  <= from_d;
      size_q  <= size_d;
      rej_q   <= rej_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      map_q   <= map_d;
      free_q  <= free_d;
      ok_q    <= ok_d;
      base_q  <= base_d;
    end
  end

  assign ready      = (state_q == ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign ok         = ok_q;
  assign base       = base_q;
  assign map        = map_q;
  assign free_count = free_q;

endmodule
